// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared frame definitions for the memory loader and debug unit
package loader_pkg;

  // Frame decoder states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    CHK  = 2'd3
  } loader_state_t;

  // Frame delimiter used by both the loader and the frame builder
  localparam logic [7:0] LOADER_START_BYTE = 8'hA5;

  // Running XOR checksum over the DATA bytes of a frame
  function automatic logic [7:0] xor_checksum(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/timeout_counter.sv
// rtl/timeout_counter.sv - inter-byte idle watchdog for the memory loader
module timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clear,
  output logic o_expired
);

  localparam int NB_CNT = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NB_CNT-1:0] LAST_IDLE = NB_CNT'(TIMEOUT_CYCLES - 1);

  logic [NB_CNT-1:0] r_cnt;
  logic              w_hit;

  // The edge that would complete TIMEOUT_CYCLES idle cycles is the expiry
  // edge; an accepted byte on that same edge (i_clear) cancels it.
  assign w_hit     = (r_cnt == LAST_IDLE);
  assign o_expired = i_en && !i_clear && w_hit;

  // Count idle cycles while enabled; restart on a byte, on expiry, or when disabled
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!i_en || i_clear || w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - framed byte-stream loader driving the memory write port
module mem_loader
  import loader_pkg::*;
#(
  parameter int                NB_DATA        = 8,
  parameter int                NB_ADDRESS     = 3,
  parameter int                N_ADDRESS      = 8,
  parameter logic [NB_DATA-1:0] START_BYTE    = NB_DATA'(LOADER_START_BYTE),
  parameter int                TIMEOUT_CYCLES = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NB_DATA-1:0]    i_rx_data,
  input  logic                  i_rx_valid,
  output logic [NB_DATA-1:0]    o_w_data,
  output logic [NB_ADDRESS-1:0] o_w_addr,
  output logic                  o_w_en,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [NB_ADDRESS:0]   o_count
);

  localparam logic [NB_DATA-1:0] MAX_LEN = NB_DATA'(N_ADDRESS);

  loader_state_t         r_state;
  logic [NB_ADDRESS:0]   r_len;
  logic [NB_ADDRESS:0]   r_addr;
  logic [NB_DATA-1:0]    r_chk;
  logic [NB_DATA-1:0]    r_w_data;
  logic [NB_ADDRESS-1:0] r_w_addr;
  logic                  r_w_en;
  logic                  r_done;
  logic                  r_error;
  logic [NB_ADDRESS:0]   r_count;

  logic                  w_expired;
  logic                  w_len_ok;
  logic [NB_ADDRESS:0]   w_addr_next;

  assign w_len_ok    = (i_rx_data != '0) && (i_rx_data <= MAX_LEN);
  assign w_addr_next = r_addr + 1'b1;

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (r_state != IDLE),
    .i_clear   (i_rx_valid),
    .o_expired (w_expired)
  );

  // Frame decoder: parses START/LEN/DATA/CHK and registers every output
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_addr   <= '0;
      r_chk    <= '0;
      r_w_data <= '0;
      r_w_addr <= '0;
      r_w_en   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_count  <= '0;
    end else begin
      r_w_en  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      if (w_expired) begin
        // Idle too long inside a frame: abort, keeping what was written
        r_state <= IDLE;
        r_error <= 1'b1;
        r_count <= r_addr;
      end else if (i_rx_valid) begin
        case (r_state)
          IDLE: begin
            if (i_rx_data == START_BYTE) begin
              r_state <= LEN;
              r_addr  <= '0;
              r_chk   <= '0;
            end
          end
          LEN: begin
            if (w_len_ok) begin
              r_len   <= i_rx_data[NB_ADDRESS:0];
              r_addr  <= '0;
              r_chk   <= '0;
              r_state <= DATA;
            end else begin
              r_error <= 1'b1;
              r_count <= '0;
              r_state <= IDLE;
            end
          end
          DATA: begin
            r_w_en   <= 1'b1;
            r_w_data <= i_rx_data;
            r_w_addr <= r_addr[NB_ADDRESS-1:0];
            r_chk    <= xor_checksum(r_chk, i_rx_data);
            r_addr   <= w_addr_next;
            if (w_addr_next == r_len) begin
              r_state <= CHK;
            end
          end
          CHK: begin
            if (i_rx_data == r_chk) begin
              r_done <= 1'b1;
            end else begin
              r_error <= 1'b1;
            end
            r_count <= r_addr;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_w_data = r_w_data;
  assign o_w_addr = r_w_addr;
  assign o_w_en   = r_w_en;
  assign o_busy   = (r_state != IDLE);
  assign o_done   = r_done;
  assign o_error  = r_error;
  assign o_count  = r_count;

endmodule

// File: doc/mem_loader.md
# mem_loader

Byte-stream loader that sits directly upstream of the data/instruction `memory` block. It consumes framed bytes from the UART receiver and decodes `START, LEN, DATA[LEN], CHK`. It drives the memory's synchronous write port, writing data bytes to consecutive addresses starting at 0. It reports frame completion, checksum or length errors, and inter-byte timeouts to the debug unit.

## Interface
Parameters:
- `NB_DATA`, 8: byte/data width, matches memory `NB_DATA`.
- `NB_ADDRESS`, 3: memory address width.
- `N_ADDRESS`, 8: memory depth; maximum legal `LEN`.
- `START_BYTE`, 8'hA5: frame delimiter.
- `TIMEOUT_CYCLES`, 1000: maximum idle cycles between bytes inside a frame.

Ports:
- `i_clk`  in  1  single clock, rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_rx_data`  in  NB_DATA  received byte.
- `i_rx_valid`  in  1  one-cycle strobe; byte accepted on the posedge where high.
- `o_w_data`  out  NB_DATA  to memory `i_w_data`.
- `o_w_addr`  out  NB_ADDRESS  to memory `i_w_addr`.
- `o_w_en`  out  1  to memory `i_w_en`.
- `o_busy`  out  1  high while a frame is in progress (state ≠ IDLE).
- `o_done`  out  1  one-cycle pulse: frame completed, checksum OK.
- `o_error`  out  1  one-cycle pulse: bad LEN, bad checksum, or timeout.
- `o_count`  out  NB_ADDRESS+1  data bytes written in the last completed or aborted frame.

## Operation
- FSM states and transitions:
  - IDLE: an accepted byte equal to `START_BYTE` goes to LEN. All other bytes are discarded silently.
  - LEN: accepted byte L. If 1 ≤ L ≤ N_ADDRESS: latch L, clear address and checksum, go to DATA. Otherwise: error, go to IDLE, no writes.
  - DATA: each accepted byte is written to the current address, XORed into the checksum, and the address is incremented. After the L-th byte, go to CHK.
  - CHK: accepted byte equal to the running XOR → `o_done`. Mismatch → `o_error`. Either way go to IDLE.
- Writes are write-through. Data already written stays in memory on any error; there is no rollback.
- Address counter is NB_ADDRESS+1 bits. `o_w_addr` is its low NB_ADDRESS bits. Because L ≤ N_ADDRESS, the address never wraps.
- A `START_BYTE` value received inside LEN, DATA or CHK is treated as ordinary payload; there is no resync.
- Timeout:
  - A counter runs only outside IDLE. It clears on each accepted byte and increments on each cycle without `i_rx_valid`.
  - When it reaches `TIMEOUT_CYCLES`: `o_error` pulses, FSM goes to IDLE, counter clears.
  - If `i_rx_valid` coincides with expiry, the byte wins: it is accepted and the counter clears.
- `o_count` updates on every `o_done` or `o_error`. It equals the number of DATA bytes written (0 for LEN errors) and holds until the next frame end.

## Timing
- Reset values: state IDLE, `o_w_en`=0, `o_w_addr`=0, `o_w_data`=0, `o_busy`=0, `o_done`=0, `o_error`=0, `o_count`=0, checksum 0, timeout counter 0.
- Byte accepted at posedge N:
  - `o_w_en`/`o_w_addr`/`o_w_data` are valid during cycle N→N+1.
  - The memory commits the byte at posedge N+1.
- `o_w_en` is high for exactly one cycle per DATA byte.
- `o_done`/`o_error` are high for the single cycle after the deciding posedge. `o_busy` drops in that same cycle.
- Throughput: `i_rx_valid` may be high on every cycle. No byte is ever dropped outside IDLE.
- `i_rst` asserted mid-frame clears all outputs immediately and asynchronously. The next frame starts at address 0; memory contents are untouched.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `loader_pkg`: state encoding localparams (IDLE, LEN, DATA, CHK), default `START_BYTE`, XOR-checksum function. The debug unit reuses this package to build frames.
- One sub-module, `timeout_counter`:
  - Parameter `TIMEOUT_CYCLES`.
  - Inputs: enable, clear.
  - Output: one-cycle `o_expired`.
  - Counter width `$clog2(TIMEOUT_CYCLES+1)`.
- Everything else (FSM, address counter, checksum, output registers) lives in `mem_loader`.

## Test plan
- Good frame: A5 03 11 22 33 00, sent back-to-back → writes 11@0, 22@1, 33@2. One `o_done` pulse, no `o_error`, `o_count`=3.
- Bad checksum: A5 02 0F F0 00 (expected FF) → writes 0F@0, F0@1. `o_error` pulse, no `o_done`, `o_count`=2.
- Bad length: A5 00, then A5 09 → `o_error` after each LEN byte, zero `o_w_en` pulses, `o_count`=0, FSM back in IDLE.
- Junk plus full depth:
  - Stimulus: 00 FF 3C, then A5 08 01..08 08, with `i_rx_valid` held every cycle.
  - Response: junk ignored; addresses 0..7 written in order; checksum 01^…^08=08 → `o_done`, `o_count`=8.
- Timeout and reset:
  - Stimulus: A5 02 11, then idle for `TIMEOUT_CYCLES` cycles.
  - Response: `o_error` in the cycle after expiry. A following good frame completes normally.
  - Stimulus: `i_rst` pulsed during DATA.
  - Response: outputs are 0 immediately, and the next frame writes from address 0.
